// File: rtl/pid_pkg.sv
// Shared types and width helpers for the incremental PID sequencer.
package pid_pkg;

  localparam int unsigned SHIFT         = 8;
  localparam int unsigned CANT_BITS_DEF = 40;
  localparam int unsigned W_IN_DEF      = 16;
  localparam int unsigned W_K_DEF       = 16;
  localparam int unsigned W_OUT_DEF     = CANT_BITS_DEF - 32;
  localparam int unsigned W_PROD_DEF    = W_IN_DEF + W_K_DEF;

  typedef enum logic [2:0] {IDLE, MAC0, MAC1, MAC2, SCALE} state_e;

  function automatic int unsigned out_width(input int unsigned cant_bits);
    return cant_bits - 32;
  endfunction

  function automatic int unsigned prod_width(input int unsigned w_in, input int unsigned w_k);
    return w_in + w_k;
  endfunction

endpackage

// File: rtl/pid_seq_sat_scale.sv
// Divide-by-2^SHIFT (floor) of the accumulator followed by signed saturation
// to the narrow command width.
module sat_scale
  import pid_pkg::*;
#(
  parameter int unsigned CANT_BITS = CANT_BITS_DEF
) (
  input  logic [CANT_BITS-1:0]            acc_i,
  output logic [out_width(CANT_BITS)-1:0] result_o,
  output logic                            clamped_o
);

  localparam int unsigned W_OUT = out_width(CANT_BITS);

  logic signed [CANT_BITS-1:0] aux;
  logic signed [CANT_BITS-1:0] max_c;
  logic signed [CANT_BITS-1:0] min_c;

  assign aux   = $signed(acc_i) >>> SHIFT;
  assign max_c = {{(CANT_BITS - W_OUT + 1){1'b0}}, {(W_OUT - 1){1'b1}}};
  assign min_c = {{(CANT_BITS - W_OUT + 1){1'b1}}, {(W_OUT - 1){1'b0}}};

  // Full-width signed compare so no high-order bits escape the range check.
  always_comb begin
    result_o  = aux[W_OUT-1:0];
    clamped_o = 1'b0;
    if (aux > max_c) begin
      result_o  = {1'b0, {(W_OUT - 1){1'b1}}};
      clamped_o = 1'b1;
    end else if (aux < min_c) begin
      result_o  = {1'b1, {(W_OUT - 1){1'b0}}};
      clamped_o = 1'b1;
    end
  end

endmodule

// File: rtl/pid_seq.sv
// Incremental PID sequencer: one shared multiplier walks three gain taps into an
// accumulator seeded with u<<8. Optional sat flag output under PID_SAT_FLAG_EN.
module pid_seq
  import pid_pkg::*;
#(
  parameter int unsigned CANT_BITS = CANT_BITS_DEF,
  parameter int unsigned W_IN      = W_IN_DEF,
  parameter int unsigned W_K       = W_K_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [W_IN-1:0]      err,
  input  logic [W_K-1:0]       k0,
  input  logic [W_K-1:0]       k1,
  input  logic [W_K-1:0]       k2,
  output logic                 busy,
  output logic                 done,
  output logic [CANT_BITS-33:0] u
`ifdef PID_SAT_FLAG_EN
  ,
  output logic                 sat
`endif
);

  localparam int unsigned W_OUT  = out_width(CANT_BITS);
  localparam int unsigned W_PROD = prod_width(W_IN, W_K);

  state_e               state_q, state_d;
  logic [W_IN-1:0]      e0_q, e0_d, e1_q, e1_d, e2_q, e2_d;
  logic [CANT_BITS-1:0] acc_q, acc_d;
  logic [W_OUT-1:0]     u_q, u_d;
  logic                 done_q, done_d;

  logic [W_K-1:0]              mul_k;
  logic [W_IN-1:0]             mul_e;
  logic signed [W_PROD-1:0]    prod;
  logic [CANT_BITS-1:0]        prod_ext;
  logic [CANT_BITS-1:0]        u_ext;
  logic [W_OUT-1:0]            scaled;
  logic                        clamped;

  always_comb begin
    mul_k = k0;
    mul_e = e0_q;
    case (state_q)
      MAC1:    begin mul_k = k1; mul_e = e1_q; end
      MAC2:    begin mul_k = k2; mul_e = e2_q; end
      default: begin mul_k = k0; mul_e = e0_q; end
    endcase
  end

  assign prod     = $signed(mul_k) * $signed(mul_e);
  assign prod_ext = {{(CANT_BITS - W_PROD){prod[W_PROD-1]}}, prod};
  assign u_ext    = {{(CANT_BITS - W_OUT){u_q[W_OUT-1]}}, u_q};

  sat_scale #(
    .CANT_BITS(CANT_BITS)
  ) u_sat_scale (
    .acc_i    (acc_q),
    .result_o (scaled),
    .clamped_o(clamped)
  );

  always_comb begin
    state_d = state_q;
    e0_d    = e0_q;
    e1_d    = e1_q;
    e2_d    = e2_q;
    acc_d   = acc_q;
    u_d     = u_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          e2_d    = e1_q;
          e1_d    = e0_q;
          e0_d    = err;
          acc_d   = u_ext << SHIFT;
          state_d = MAC0;
        end
      end
      MAC0: begin
        acc_d   = acc_q + prod_ext;
        state_d = MAC1;
      end
      MAC1: begin
        acc_d   = acc_q + prod_ext;
        state_d = MAC2;
      end
      MAC2: begin
        acc_d   = acc_q + prod_ext;
        state_d = SCALE;
      end
      SCALE: begin
        u_d     = scaled;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      e0_q    <= '0;
      e1_q    <= '0;
      e2_q    <= '0;
      acc_q   <= '0;
      u_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      e2_q    <= e2_d;
      acc_q   <= acc_d;
      u_q     <= u_d;
      done_q  <= done_d;
    end
  end

  // busy spans the done cycle, which already sits back in IDLE.
  assign busy = (state_q != IDLE) | done_q;
  assign done = done_q;
  assign u    = u_q;

`ifdef PID_SAT_FLAG_EN
  logic sat_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_q <= 1'b0;
    end else if (state_q == SCALE) begin
      sat_q <= clamped;
    end
  end

  assign sat = sat_q;
`else
  logic clamped_unused;
  assign clamped_unused = clamped;
`endif

endmodule

// File: tb/tb_pid_seq.sv
// Self-checking bench for pid_seq: directed scenarios then randomized
// transactions against an arithmetic reference of the PID update.
module tb_pid_seq;

  localparam int CB = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] err;
  logic [15:0] k0, k1, k2;
  logic        busy, done;
  logic [7:0]  u;
  logic        sat;

  int checks = 0;
  int errors = 0;

  int u_m, sat_m;
  int e0_m, e1_m, e2_m;
  int k0_m, k1_m, k2_m;

  always #5 clk = ~clk;

  pid_seq #(.CANT_BITS(CB), .W_IN(16), .W_K(16)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .err  (err),
    .k0   (k0),
    .k1   (k1),
    .k2   (k2),
    .busy (busy),
    .done (done),
    .u    (u)
`ifdef PID_SAT_FLAG_EN
    ,
    .sat  (sat)
`endif
  );

`ifndef PID_SAT_FLAG_EN
  assign sat = 1'b0;
`endif

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_gains(input int a, input int b, input int c);
    k0_m = a; k1_m = b; k2_m = c;
    k0 = a[15:0]; k1 = b[15:0]; k2 = c[15:0];
  endtask

  function automatic void model_reset();
    u_m = 0; sat_m = 0; e0_m = 0; e1_m = 0; e2_m = 0;
  endfunction

  function automatic void model_apply(input int e);
    longint acc, aux;
    e2_m = e1_m; e1_m = e0_m; e0_m = e;
    acc = longint'(u_m) * 256 + longint'(k0_m) * e0_m
        + longint'(k1_m) * e1_m + longint'(k2_m) * e2_m;
    acc = (acc <<< (64 - CB)) >>> (64 - CB);
    aux = acc >>> 8;
    if (aux > 127)       begin u_m = 127;  sat_m = 1; end
    else if (aux < -128) begin u_m = -128; sat_m = 1; end
    else                 begin u_m = int'(aux); sat_m = 0; end
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_u", $signed(u), 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sat", sat, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
    end
  endtask

  // Ends 1 time unit after edge T4; extra pulses start so it is sampled at T1 and T4.
  task automatic run(input int e, input bit extra);
    err   = e[15:0];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model_apply(e);
    check("t0_busy", busy, 1);
    check("t0_done", done, 0);
    if (extra) start = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (extra && i == 3) start = 1'b1;
      if (i < 4) begin
        check("mac_done", done, 0);
        check("mac_busy", busy, 1);
      end else begin
        check("t4_done", done, 1);
        check("t4_busy", busy, 1);
        check("t4_u", $signed(u), u_m);
`ifdef PID_SAT_FLAG_EN
        check("t4_sat", sat, sat_m);
`endif
      end
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; err = '0;
    set_gains(0, 0, 0);
    model_reset();
    #2;

    do_reset();
    set_gains(256, 0, 0);
    run(5, 0);
    idle(2);

    do_reset();
    set_gains(1, 0, 0);
    run(-1, 0);
    idle(1);

    do_reset();
    set_gains(32767, 0, 0);
    run(32767, 0);
    idle(1);
    set_gains(-32768, 0, 0);
    run(32767, 0);
    idle(1);
    run(32767, 0);
    idle(1);

    do_reset();
    set_gains(256, 0, 0);
    run(1, 0);
    run(1, 0);
    run(1, 0);
    idle(1);
    set_gains(0, 256, 0);
    run(9, 0);
    idle(1);

    do_reset();
    set_gains(256, 0, 0);
    run(4, 1);
    idle(3);
    set_gains(0, 256, 256);
    run(7, 0);
    idle(1);

    do_reset();
    set_gains(256, 0, 0);
    err = 16'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("mid_rst_u", $signed(u), 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    idle(6);
    run(2, 0);
    idle(1);

    do_reset();
    for (int n = 0; n < 60; n++) begin
      int g[3];
      for (int j = 0; j < 3; j++) begin
        if ($urandom_range(0, 1) == 0) g[j] = int'($urandom_range(0, 65535)) - 32768;
        else                           g[j] = int'($urandom_range(0, 600)) - 300;
      end
      set_gains(g[0], g[1], g[2]);
      if ($urandom_range(0, 3) == 0) run(int'($urandom_range(0, 65535)) - 32768, $urandom_range(0, 1) == 1);
      else                           run(int'($urandom_range(0, 200)) - 100, 0);
      idle(int'($urandom_range(0, 2)));
    end
    idle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
